// File: rtl/dec_forward_unit.sv
// dec_forward_unit: serial binary-to-decimal converter.
// A 16-bit unsigned value is captured on a one-cycle load strobe and then
// streamed as dig_cnt BCD digits, most-significant first, over an rts/cts
// handshake. Each digit is found by repeated subtraction of the matching
// power of ten. Values that do not fit in dig_cnt digits are emitted as all 9s.
module dec_forward_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] bdata,
   input  logic        load,
   input  logic [3:0]  dig_cnt,
   output logic [3:0]  nib_out,
   output logic        rts,
   input  logic        cts
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t      state;
   logic [16:0] rem;
   logic [3:0]  k;
   logic [3:0]  dig;
   logic        ovf;

   // Power of ten for digit position k; positions above 4 can never be
   // non-zero for a 16-bit value, so they map to 0 and are never used.
   function automatic logic [16:0] pow10(input logic [3:0] pos);
      logic [16:0] p;
      case (pos)
         4'd0:    p = 17'd1;
         4'd1:    p = 17'd10;
         4'd2:    p = 17'd100;
         4'd3:    p = 17'd1000;
         4'd4:    p = 17'd10000;
         default: p = 17'd0;
      endcase
      return p;
   endfunction

   // True when the value cannot be written with the requested digit count.
   // Five or more digits always hold a 16-bit value.
   function automatic logic too_big(input logic [15:0] val, input logic [3:0] cnt);
      return (cnt <= 4'd4) && ({1'b0, val} >= pow10(cnt));
   endfunction

   // Conversion FSM with registered rts/nib_out; load restarts from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rem     <= '0;
         k       <= '0;
         dig     <= '0;
         ovf     <= 1'b0;
         rts     <= 1'b0;
         nib_out <= '0;
      end else if (load) begin
         rem   <= {1'b0, bdata};
         k     <= dig_cnt - 4'd1;
         dig   <= '0;
         ovf   <= too_big(bdata, dig_cnt);
         rts   <= 1'b0;
         state <= (dig_cnt != 4'd0) ? CALC : IDLE;
      end else begin
         case (state)
            CALC: begin
               if (ovf) begin
                  dig     <= 4'd9;
                  nib_out <= 4'd9;
                  rts     <= 1'b1;
                  state   <= EMIT;
               end else if (k >= 4'd5) begin
                  dig     <= 4'd0;
                  nib_out <= 4'd0;
                  rts     <= 1'b1;
                  state   <= EMIT;
               end else if (rem >= pow10(k)) begin
                  rem <= rem - pow10(k);
                  dig <= dig + 4'd1;
               end else begin
                  nib_out <= dig;
                  rts     <= 1'b1;
                  state   <= EMIT;
               end
            end
            EMIT: begin
               // Without cts the digit and rts simply hold.
               if (cts) begin
                  rts <= 1'b0;
                  if (k == 4'd0) begin
                     state <= IDLE;
                  end else begin
                     k     <= k - 4'd1;
                     dig   <= 4'd0;
                     state <= CALC;
                  end
               end
            end
            default: begin
               rts   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dec_forward_unit.sv
// Bench for dec_forward_unit: digit sequences are compared with a decimal
// model built from plain division; a negedge monitor collects transfers and
// watches the handshake (hold while stalled, gap after each transfer).
module tb_dec_forward_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] bdata = '0;
   logic        load = 1'b0;
   logic [3:0]  dig_cnt = '0;
   logic [3:0]  nib_out;
   logic        rts;
   logic        cts = 1'b0;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int last_cyc = 0;
   int load_cyc = 0;
   bit cts_rand = 1'b0;
   int got[$];
   int exp_q[$];

   bit       prev_stall = 1'b0;
   bit       prev_xfer = 1'b0;
   logic [3:0] prev_nib = '0;

   dec_forward_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bdata   (bdata),
      .load    (load),
      .dig_cnt (dig_cnt),
      .nib_out (nib_out),
      .rts     (rts),
      .cts     (cts)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic bit is_ovf(input int v, input int n);
      longint lim = 1;
      for (int j = 0; j < n; j++) lim = lim * 10;
      return (n <= 4) && (longint'(v) >= lim);
   endfunction

   // Decimal digits of v, n wide, MSB first; all 9s when v does not fit.
   function automatic void build_exp(input int v, input int n);
      bit ov = is_ovf(v, n);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         longint p = 1;
         for (int j = 0; j < n - 1 - i; j++) p = p * 10;
         exp_q.push_back(ov ? 9 : int'((longint'(v) / p) % 10));
      end
   endfunction

   // Transfer monitor, sampled mid-cycle so all DUT outputs are settled.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_xfer  = 1'b0;
      end else begin
         if (prev_xfer) check("gap_after_xfer", rts, 0);
         if (prev_stall) begin
            check("stall_rts_hold", rts, 1);
            check("stall_nib_hold", nib_out, prev_nib);
         end
         prev_xfer  = rts && cts;
         prev_stall = rts && !cts;
         prev_nib   = nib_out;
         if (rts && cts) begin
            got.push_back(int'(nib_out));
            last_cyc = cyc;
         end
      end
   end

   // Random consumer readiness when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cts_rand) cts = 1'($urandom_range(0, 1));
      end
   end

   // Caller is positioned just after a rising edge with rts low.
   task automatic run_conv(input int v, input int n, input string tag, input bit chk_lat);
      int acc;
      got.delete();
      load     = 1'b1;
      bdata    = 16'(v);
      dig_cnt  = 4'(n);
      load_cyc = cyc;
      @(posedge clk);
      #1;
      load  = 1'b0;
      bdata = 'x;
      build_exp(v, n);
      for (int t = 0; t < 3000 && got.size() < n; t++) @(posedge clk);
      repeat (30) @(posedge clk);
      #1;
      check({tag, "_count"}, got.size(), n);
      acc = 0;
      for (int i = 0; i < n && i < got.size(); i++) begin
         check($sformatf("%s_dig%0d", tag, i), got[i], exp_q[i]);
         acc = acc * 10 + got[i];
      end
      if (n > 0 && !is_ovf(v, n) && got.size() == n)
         check({tag, "_recon"}, acc, v);
      check({tag, "_rts_idle"}, rts, 0);
      if (chk_lat && n > 0)
         check({tag, "_latency_ok"}, (last_cyc - load_cyc) <= 11 * n + 2, 1);
   endtask

   initial begin
      int v;
      int n;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rts", rts, 0);
      check("reset_nib", nib_out, 0);
      rst_n = 1'b1;
      cts   = 1'b1;
      @(posedge clk);
      #1;

      run_conv(123, 8, "v123", 1);
      run_conv(60875, 8, "v60875", 1);
      for (int i = 0; i < 6; i++)
         run_conv(int'($urandom_range(0, 65535)), 8, $sformatf("rnd8_%0d", i), 1);
      run_conv(65535, 5, "max5", 1);
      run_conv(0, 5, "zero5", 1);
      run_conv(4321, 0, "cnt0", 0);
      run_conv(1234, 3, "ovf3", 1);
      run_conv(9999, 4, "fit4", 1);
      run_conv(10000, 4, "ovf4", 1);
      for (int i = 0; i < 8; i++) begin
         v = (i % 2 == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 999));
         n = int'($urandom_range(1, 8));
         run_conv(v, n, $sformatf("rndn_%0d", i), 1);
      end

      // Random consumer readiness.
      cts_rand = 1'b1;
      run_conv(60875, 8, "rcts60875", 0);
      for (int i = 0; i < 3; i++)
         run_conv(int'($urandom_range(0, 65535)), 8, $sformatf("rcts_%0d", i), 0);
      cts_rand = 1'b0;
      @(posedge clk);
      #1;
      cts = 1'b1;

      // Abort: restart mid-conversion with a new value.
      load    = 1'b1;
      bdata   = 16'd60875;
      dig_cnt = 4'd8;
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      for (int t = 0; t < 50 && rts; t++) begin
         @(posedge clk);
         #1;
      end
      check("abort_pre_rts_low", rts, 0);
      run_conv(70, 8, "abort70", 0);

      // Reset mid-conversion.
      load    = 1'b1;
      bdata   = 16'd60875;
      dig_cnt = 4'd8;
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_rts", rts, 0);
      check("midrst_nib", nib_out, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      repeat (40) @(posedge clk);
      #1;
      check("postrst_quiet", got.size(), 0);
      check("postrst_rts", rts, 0);
      run_conv(60875, 8, "postrst", 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
